fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter N, default 32, meaning datapath/address width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  downstream hold; held instruction not released.
REQ-006 SHALL have port instr_ready  input  1  downstream accepts held instruction.
REQ-007 SHALL have port branch_en  input  1  redirect request, single-cycle.
REQ-008 SHALL have port branch_target  input  N  redirect address.
REQ-009 SHALL have port imem_req  output  1  instruction memory request.
REQ-010 SHALL have port imem_addr  output  N  request address, registered.
REQ-011 SHALL have port imem_ack  input  1  memory returns data this cycle.
REQ-012 SHALL have port imem_rdata  input  N  returned instruction word.
REQ-013 SHALL have port instr_valid  output  1  instr/pc_out/r15_out valid.
REQ-014 SHALL have port instr  output  N  held instruction word.
REQ-015 SHALL have port pc_out  output  N  address of held instruction.
REQ-016 SHALL have port r15_out  output  N  pc_out+8, drives register file R15 input.

Function
REQ-017 SHALL implement FSM states FETCH, HOLD, FLUSH.
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_ack latch imem_rdata->instr, pc->pc_out, pc<=pc+4, go HOLD.
REQ-019 HOLD: instr_valid=1, imem_req=0; on instr_ready=1 and stall=0 go FETCH with instr_valid=0 next cycle.
REQ-020 stall=1 in HOLD SHALL keep instr, pc_out, instr_valid stable regardless of instr_ready.
REQ-021 imem_req, once asserted, SHALL stay 1 with imem_addr stable until imem_ack; stall never withdraws it.
REQ-022 branch_en SHALL have highest priority; pc<=branch_target with bits [1:0] forced to 0.
REQ-023 branch_en in FETCH without imem_ack: go FLUSH; request stays pending at old imem_addr.
REQ-024 branch_en in FETCH with imem_ack same cycle: discard imem_rdata, stay FETCH at new pc.
REQ-025 branch_en in HOLD: instr_valid=0 next cycle, go FETCH at new pc.
REQ-026 FLUSH: on imem_ack discard data, go FETCH; branch_en in FLUSH overwrites pc, stays FLUSH.
REQ-027 pc+4 and pc_out+8 SHALL wrap modulo 2^N; r15_out combinational from pc_out.
REQ-028 Throughput: one instruction per two cycles minimum with zero-wait memory and instr_ready=1.

Reset
REQ-029 rst=0 SHALL immediately force: state FETCH, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, pc_out=RESET_PC, r15_out=RESET_PC+8.
REQ-030 First imem_req=1 SHALL appear the cycle after rst deasserts; reset mid-request abandons it, ack during reset ignored.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined: output fetch_count (32 bits), +1 per instruction released in HOLD, reset 0, wraps at 2^32.
REQ-032 Macro FETCH_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.

Structure
REQ-033 Package fetch_pkg SHALL hold fetch_state_t enum (FETCH, HOLD, FLUSH), PC_INCR=4, R15_OFFSET=8.
REQ-034 One sub-module pc_next SHALL compute next pc (branch/increment/hold select, alignment mask).

Verification
REQ-035 Reset, RESET_PC=0x100, ack every req -> imem_addr 0x100,0x104,0x108; r15_out 0x108,0x10C,0x110.
REQ-036 Ack delayed 3 cycles -> imem_req and imem_addr=0x100 stable all 3 cycles, then instr_valid=1.
REQ-037 HOLD with stall=1, instr_ready=1 for 4 cycles -> instr/pc_out unchanged, no new imem_req.
REQ-038 branch_en, target 0x203, in FETCH before ack -> FLUSH, late data discarded, next imem_addr=0x200.
REQ-039 branch_en same cycle as ack -> no instr_valid for that data, next imem_addr=target.
REQ-040 pc=0xFFFFFFFC fetched -> next imem_addr=0x0; r15_out=0x4; with FETCH_PERF_CNT_EN fetch_count increments per release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INCR    = 4;
  localparam int unsigned R15_OFFSET = 8;

endpackage

// File: rtl/pc_next.sv
// Next-pc select: aligned branch target, sequential increment, or hold.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] i_pc,
  input  logic         i_branch_en,
  input  logic [N-1:0] i_branch_target,
  input  logic         i_incr,
  output logic [N-1:0] o_pc_next
);

  always_comb begin
    o_pc_next = i_pc;
    if (i_branch_en) begin
      o_pc_next = {i_branch_target[N-1:2], 2'b00};
    end else if (i_incr) begin
      o_pc_next = i_pc + N'(PC_INCR);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/HOLD/FLUSH control with branch redirect.
// Defining FETCH_PERF_CNT_EN adds the fetch_count released-instruction counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         instr_ready,
  input  logic         branch_en,
  input  logic [N-1:0] branch_target,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [N-1:0] instr,
  output logic [N-1:0] pc_out,
  output logic [N-1:0] r15_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_count
`endif
);

  fetch_state_t r_state;
  logic [N-1:0] r_pc;
  logic         r_imem_req;
  logic [N-1:0] r_imem_addr;
  logic         r_instr_valid;
  logic [N-1:0] r_instr;
  logic [N-1:0] r_pc_out;
  logic [N-1:0] w_pc_next;
  logic         w_incr;
  logic         w_release;

  // Only an accepted, non-redirected response advances the pc.
  assign w_incr    = (r_state == FETCH) && r_imem_req && imem_ack && !branch_en;
  assign w_release = (r_state == HOLD) && !branch_en && instr_ready && !stall;

  pc_next #(
    .N(N)
  ) u_pc_next (
    .i_pc           (r_pc),
    .i_branch_en    (branch_en),
    .i_branch_target(branch_target),
    .i_incr         (w_incr),
    .o_pc_next      (w_pc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_pc_out      <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
      case (r_state)
        FETCH: begin
          if (!r_imem_req) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= w_pc_next;
          end else if (branch_en) begin
            // Without an ack the old request must still complete, so drain it in FLUSH.
            if (imem_ack) r_imem_addr <= w_pc_next;
            else          r_state     <= FLUSH;
          end else if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_pc_out      <= r_pc;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (branch_en || w_release) begin
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_imem_addr   <= w_pc_next;
            r_state       <= FETCH;
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            r_imem_addr <= w_pc_next;
            r_state     <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_count <= '0;
    end else if (w_release) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign pc_out      = r_pc_out;
  assign r15_out     = r_pc_out + N'(R15_OFFSET);

endmodule
